// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM. Each transaction
// takes IDLE -> ACCESS -> DONE, and ties are broken against the last port served.
module ram_arbiter #(
    parameter int addrBits = 16,
    parameter int dataBits = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0,
    input  logic                req1,
    input  logic                rw0,
    input  logic                rw1,
    input  logic [addrBits-1:0] addr0,
    input  logic [addrBits-1:0] addr1,
    input  logic [dataBits-1:0] wdata0,
    input  logic [dataBits-1:0] wdata1,
    output logic                grant0,
    output logic                grant1,
    output logic                done0,
    output logic                done1,
    output logic [dataBits-1:0] rdata0,
    output logic [dataBits-1:0] rdata1,
    output logic [addrBits-1:0] ramAddr,
    output logic [dataBits-1:0] ramDataIn,
    output logic                ramRW,
    input  logic [dataBits-1:0] ramDataOut
);

    if (addrBits != dataBits) begin : g_width_check
        $error("ram_arbiter: addrBits must equal dataBits");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  port_q, port_d;
    logic                  rw_q, rw_d;
    logic [addrBits-1:0]   addr_q, addr_d;
    logic [dataBits-1:0]   wdata_q, wdata_d;
    logic                  last_q, last_d;
    logic [dataBits-1:0]   rdata0_q, rdata0_d;
    logic [dataBits-1:0]   rdata1_q, rdata1_d;
    logic                  in_done;
    logic                  read_done;

    always_comb begin
        // NOTE: every target gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        port_d   = port_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        last_d   = last_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // A lone requester wins; on a tie the port not served last wins.
                    port_d  = (req0 && req1) ? ~last_q : req1;
                    rw_d    = port_d ? rw1    : rw0;
                    addr_d  = port_d ? addr1  : addr0;
                    wdata_d = port_d ? wdata1 : wdata0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!rw_q) begin
                    if (port_q) begin
                        rdata1_d = ramDataOut;
                    end else begin
                        rdata0_d = ramDataOut;
                    end
                end
                last_d  = port_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register samples the pre-edge values together.
        if (reset) begin
            state_q  <= S_IDLE;
            port_q   <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            last_q   <= 1'b1;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            last_q   <= last_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Reset masks the write strobe and completion so an aborted transaction leaves no trace.
    assign in_done   = (state_q == S_DONE) && !reset;
    assign read_done = in_done && !rw_q;

    assign grant0 = (state_q != S_IDLE) && !port_q;
    assign grant1 = (state_q != S_IDLE) &&  port_q;
    assign done0  = in_done && !port_q;
    assign done1  = in_done &&  port_q;

    // Read data is forwarded during DONE so it is valid with the done pulse, then held from the register.
    assign rdata0 = (read_done && !port_q) ? ramDataOut : rdata0_q;
    assign rdata1 = (read_done &&  port_q) ? ramDataOut : rdata1_q;

    assign ramAddr   = addr_q;
    assign ramDataIn = wdata_q;
    assign ramRW     = (state_q == S_ACCESS) && rw_q && !reset;

endmodule
